// File: rtl/step_scheduler_if.sv
// Trigger handshake between the step scheduler and the sample playback engine.
// The scheduler is the master: it presents a 4-bit sample mask with a valid flag
// and the playback engine answers with ready.
interface step_scheduler_if;
    logic       trig_valid;
    logic [3:0] trig_smpl;
    logic       trig_ready;

    modport master (
        output trig_valid,
        output trig_smpl,
        input  trig_ready
    );

    modport slave (
        input  trig_valid,
        input  trig_smpl,
        output trig_ready
    );
endinterface

// File: rtl/step_scheduler.sv
// Drum step sequencer playback controller.
// Walks an 8-step pattern at a programmable tempo and issues each step's
// sample-trigger mask over a valid/ready handshake. A newer trigger always
// replaces an unaccepted one and the loss is flagged with a one-cycle pulse.
module step_scheduler #(
    parameter int TICK_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [TICK_W-1:0]   step_period,
    input  logic [31:0]         pattern,
    step_scheduler_if.master    trig_bus,
    output logic                trig_drop,
    output logic [2:0]          step_idx,
    output logic                step_tick,
    output logic                playing
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [3:0]        smpl_q, smpl_d;
    logic              drop_q, drop_d;
    logic              tick_q, tick_d;
    logic              play_q, play_d;
    logic [TICK_W-1:0] last_tick_s;
    logic              load_s;
    logic [3:0]        nib_s;

    // Step k occupies pattern[31-4k -: 4], so step 0 is the top nibble.
    function automatic logic [3:0] step_nibble(input logic [31:0] pat, input logic [2:0] idx);
        step_nibble = pat[{3'd7 - idx, 2'b00} +: 4];
    endfunction

    // Last tick index of a step; periods below 2 behave as 2.
    always_comb begin
        if (step_period < TICK_W'(2)) begin
            last_tick_s = TICK_W'(1);
        end else begin
            last_tick_s = step_period - TICK_W'(1);
        end
    end

    // Next-state, step counter and trigger-path logic.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        smpl_d     = smpl_q;
        drop_d     = 1'b0;
        tick_d     = 1'b0;
        load_s     = 1'b0;
        nib_s      = 4'h0;

        // Acceptance first; a load on the same edge overrides it below.
        if (valid_q && trig_bus.trig_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_STOP: begin
                if (mode == 2'd1) begin
                    state_d    = ST_RUN;
                    tick_cnt_d = '0;
                    idx_d      = 3'd0;
                    tick_d     = 1'b1;
                    load_s     = 1'b1;
                end else begin
                    state_d    = ST_STOP;
                    tick_cnt_d = '0;
                    idx_d      = 3'd0;
                    valid_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (mode == 2'd0) begin
                    state_d    = ST_STOP;
                    tick_cnt_d = '0;
                    idx_d      = 3'd0;
                    valid_d    = 1'b0;
                end else if (mode != 2'd1) begin
                    // Pause edge freezes the counter without counting.
                    state_d = ST_PAUSE;
                end else if (tick_cnt_q >= last_tick_s) begin
                    // >= so a shortened period fires at once rather than wrapping.
                    tick_cnt_d = '0;
                    idx_d      = idx_q + 3'd1;
                    tick_d     = 1'b1;
                    load_s     = 1'b1;
                end else begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                end
            end
            ST_PAUSE: begin
                if (mode == 2'd0) begin
                    state_d    = ST_STOP;
                    tick_cnt_d = '0;
                    idx_d      = 3'd0;
                    valid_d    = 1'b0;
                end else if (mode == 2'd1) begin
                    // Resume edge does not count; counting restarts next edge.
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d    = ST_STOP;
                tick_cnt_d = '0;
                idx_d      = 3'd0;
                valid_d    = 1'b0;
            end
        endcase

        // Empty steps leave any pending trigger untouched.
        if (load_s) begin
            nib_s = step_nibble(pattern, idx_d);
        end else begin
            nib_s = 4'h0;
        end

        if (load_s && (nib_s != 4'h0)) begin
            if (valid_q && !trig_bus.trig_ready) begin
                drop_d = 1'b1;
            end else begin
                drop_d = 1'b0;
            end
            valid_d = 1'b1;
            smpl_d  = nib_s;
        end else begin
            smpl_d = smpl_q;
        end

        play_d = (state_d == ST_RUN);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_STOP;
            tick_cnt_q <= '0;
            idx_q      <= 3'd0;
            valid_q    <= 1'b0;
            smpl_q     <= 4'h0;
            drop_q     <= 1'b0;
            tick_q     <= 1'b0;
            play_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            smpl_q     <= smpl_d;
            drop_q     <= drop_d;
            tick_q     <= tick_d;
            play_q     <= play_d;
        end
    end

    assign trig_bus.trig_valid = valid_q;
    assign trig_bus.trig_smpl  = smpl_q;
    assign trig_drop           = drop_q;
    assign step_idx            = idx_q;
    assign step_tick           = tick_q;
    assign playing             = play_q;

endmodule

// File: doc/step_scheduler.md
Name: step_scheduler

Overview:
- Playback controller for the drum step sequencer.
- Walks the 8-step pattern produced by the sequence editor at a programmable tempo.
- At each step boundary it issues that step's 4-bit sample-trigger mask to the sample playback engine over a valid/ready handshake.
- The same `mode` bus drives both blocks: the editor is active in mode 0, this block plays in mode 1.

Parameters:
- TICK_W, 24, width of the step-period counter and the `step_period` input.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  0=edit/stop, 1=play, 2=pause, 3=pause (same as 2)
- step_period  in  TICK_W  clk cycles per step; values below 2 are treated as 2
- pattern  in  32  step k mask at bits [31-4k -: 4]; step 0 = [31:28] (seq_smpl_1 … seq_smpl_8 concatenated)
- trig_ready  in  1  playback engine accepts the trigger
- trig_valid  out  1  trigger pending
- trig_smpl  out  4  sample mask of the pending trigger; stable while trig_valid=1
- trig_drop  out  1  one-cycle pulse: an unaccepted trigger was overwritten
- step_idx  out  3  current step, 0..7
- step_tick  out  1  one-cycle pulse in the first cycle of each step
- playing  out  1  high when state==RUN

Behaviour:
- Reset (rst_n low, async): state STOP; tick_cnt, step_idx, trig_valid, trig_smpl, trig_drop, step_tick, playing all 0. Reset may assert at any time and overrides everything.
- eff_period = max(step_period, 2).
- FSM state STOP:
  - step_idx=0, tick_cnt=0, no triggers.
  - On an edge with mode==1 → RUN with tick_cnt<=0, step_idx<=0, step_tick<=1, and step 0 loaded into the trigger path.
  - Outputs appear in the cycle after mode==1 is first sampled.
- FSM state RUN:
  - tick_cnt increments every edge.
  - On an edge where tick_cnt >= eff_period-1: tick_cnt<=0, step_idx<=step_idx+1 (7 wraps to 0), step_tick<=1, and the new step's nibble is loaded.
  - The comparison uses >=, so shrinking step_period mid-step fires on the next edge (no counter wrap).
  - Steady-state step spacing is exactly eff_period cycles.
  - On an edge with mode==2/3 → PAUSE.
- FSM state PAUSE:
  - tick_cnt and step_idx are frozen; no new steps.
  - A pending trigger stays valid and can still be accepted.
  - On an edge with mode==1 → RUN. The transition edge does not count, and no immediate trigger fires; counting resumes from the frozen tick_cnt.
- mode==0 in any state: → STOP on that edge. step_idx<=0, tick_cnt<=0, trig_valid<=0 (pending trigger discarded silently, no trig_drop).
- Pattern is sampled only at the load edge; later pattern edits do not alter a pending trigger.
- Trigger load:
  - A nonzero nibble sets trig_valid<=1 and trig_smpl<=nibble.
  - A zero nibble issues no trigger; the current pending trigger is unaffected.
- Accept: on an edge with trig_valid && trig_ready, trig_valid<=0 unless a load occurs on the same edge.
- Collision: on a load edge with trig_valid=1 and trig_ready=0 and a nonzero new nibble:
  - the old trigger is overwritten (latest wins);
  - trig_drop<=1 for one cycle.
  - If trig_ready=1 on that edge, the old trigger is accepted, the new one becomes pending, and there is no drop.
- step_tick and trig_drop are 1 for exactly one cycle per event; otherwise 0.
- Mode changes, including direct PAUSE→STOP and STOP→PAUSE (stays STOP), take effect at the sampling edge. Mode is registered by upstream logic; no synchronizer is in this block.

Test Plan:
1. Basic play, step_period=4, pattern=32'h1200_0008, trig_ready=1, mode 0→1:
   - step_tick every 4 cycles starting the cycle after mode=1;
   - trig_smpl 1 at step 0 and 2 at step 1; no triggers at steps 2–6; 8 at step 7;
   - step_idx wraps 7→0 and re-triggers 1.
2. Backpressure, pattern=32'hFFFF_FFFF, trig_ready=0, step_period=3:
   - trig_valid stays 1 with trig_smpl=F;
   - trig_drop pulses at each step from step 1 on;
   - trig_ready=1 for one cycle clears trig_valid until the next step.
3. Pause/resume, step_period=4:
   - mode=2 with tick_cnt=2 in step 3 and hold 10 cycles: step_idx stays 3, no step_tick.
   - mode=1: step_tick for step 4 appears 2 cycles after the first RUN cycle.
4. Period edge cases:
   - step_period=0 or 1 → step_tick every 2 cycles.
   - step_period changed 100→4 at tick_cnt=50 → step fires on the next edge, then every 4 cycles.
5. Stop with pending trigger (trig_ready=0, trig_valid=1), mode=0 → next cycle trig_valid=0, step_idx=0, playing=0, trig_drop=0.
6. Async reset mid-RUN: rst_n low between clock edges → all outputs 0 immediately. Release with mode=1 → restarts at step 0 with immediate step_tick.
